// File: rtl/feature_map_collector.sv
// Capture sink for the accelerator output stream: buffers every accepted word in
// arrival order, keeps count/min/max/per-channel statistics, then exposes a read port.
module feature_map_collector #(
    parameter int N            = 16,
    parameter int FEATURE_SIZE = 112,
    parameter int OUT_CHANNELS = 16,
    localparam int TOTAL = FEATURE_SIZE * FEATURE_SIZE * OUT_CHANNELS,
    localparam int AW    = $clog2(TOTAL),
    localparam int CW    = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    input  logic [CW-1:0] in_channel,
    output logic          in_ready,
    output logic          done,
    output logic          overflow,
    output logic [AW:0]   word_count,
    output logic [AW:0]   nonzero_cnt,
    output logic [N-1:0]  min_val,
    output logic [N-1:0]  max_val,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data,
    output logic          rd_valid,
    input  logic [CW-1:0] ch_sel,
    output logic [AW:0]   ch_count
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t         state_q, state_d;
    logic           started_q, started_d;
    logic           overflow_q, overflow_d;
    logic [AW:0]    wc_q, wc_d;
    logic [AW:0]    nz_q, nz_d;
    logic [N-1:0]   min_q, min_d;
    logic [N-1:0]   max_q, max_d;
    logic [AW:0]    chan_cnt_q [OUT_CHANNELS];
    logic [AW:0]    chan_cnt_d [OUT_CHANNELS];
    logic           accept;
    logic [N-1:0]   rd_data_q;
    logic           rd_valid_q;
    logic           rd_in_range;
    logic [N-1:0]   mem [TOTAL];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            started_q  <= 1'b0;
            overflow_q <= 1'b0;
            wc_q       <= '0;
            nz_q       <= '0;
            min_q      <= '1;
            max_q      <= '0;
            for (int c = 0; c < OUT_CHANNELS; c++) chan_cnt_q[c] <= '0;
        end else begin
            state_q    <= state_d;
            started_q  <= started_d;
            overflow_q <= overflow_d;
            wc_q       <= wc_d;
            nz_q       <= nz_d;
            min_q      <= min_d;
            max_q      <= max_d;
            for (int c = 0; c < OUT_CHANNELS; c++) chan_cnt_q[c] <= chan_cnt_d[c];
        end
    end

    always_comb begin
        state_d    = state_q;
        started_d  = started_q;
        overflow_d = overflow_q;
        wc_d       = wc_q;
        nz_d       = nz_q;
        min_d      = min_q;
        max_d      = max_q;
        chan_cnt_d = chan_cnt_q;
        accept     = 1'b0;
        // start takes priority: a beat arriving with start is dropped, not captured
        if (start) begin
            state_d    = CAPTURE;
            started_d  = 1'b1;
            overflow_d = 1'b0;
            wc_d       = '0;
            nz_d       = '0;
            min_d      = '1;
            max_d      = '0;
            for (int c = 0; c < OUT_CHANNELS; c++) chan_cnt_d[c] = '0;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (in_valid) begin
                        accept = 1'b1;
                        wc_d   = wc_q + 1'b1;
                        for (int c = 0; c < OUT_CHANNELS; c++)
                            if (in_channel == CW'(c)) chan_cnt_d[c] = chan_cnt_q[c] + 1'b1;
                        if (in_data != '0) begin
                            nz_d = nz_q + 1'b1;
                            if (in_data < min_q) min_d = in_data;
                        end
                        if (in_data > max_q) max_d = in_data;
                        if (wc_q == (AW+1)'(TOTAL - 1)) state_d = DONE;
                    end
                end
                default: begin
                    if (in_valid && started_q) overflow_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wc_q[AW-1:0]] <= in_data;
    end

    generate
        if (TOTAL == (1 << AW)) begin : g_full_range
            assign rd_in_range = 1'b1;
        end else begin : g_part_range
            assign rd_in_range = (32'(rd_addr) < TOTAL);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (rd_en && state_q == DONE) begin
            rd_data_q  <= rd_in_range ? mem[rd_addr] : '0;
            rd_valid_q <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    always_comb begin
        ch_count = '0;
        for (int c = 0; c < OUT_CHANNELS; c++)
            if (ch_sel == CW'(c)) ch_count = chan_cnt_q[c];
    end

    assign in_ready    = (state_q == CAPTURE);
    assign done        = (state_q == DONE);
    assign overflow    = overflow_q;
    assign word_count  = wc_q;
    assign nonzero_cnt = nz_q;
    assign min_val     = min_q;
    assign max_val     = max_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_feature_map_collector.sv
// Scoreboard bench for feature_map_collector: small 2x2x2 instance for directed
// cases, plus a 4x4x4 instance for a longer round-robin capture against a model.
module tb_feature_map_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- small instance: TOTAL=8, AW=3, CW=1 ----------------
    logic        rst, start, in_valid, rd_en;
    logic [15:0] in_data;
    logic [0:0]  in_channel, ch_sel;
    logic [2:0]  rd_addr;
    logic        in_ready, done, overflow, rd_valid;
    logic [3:0]  word_count, nonzero_cnt, ch_count;
    logic [15:0] min_val, max_val, rd_data;

    feature_map_collector #(.N(16), .FEATURE_SIZE(2), .OUT_CHANNELS(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_channel(in_channel), .in_ready(in_ready), .done(done), .overflow(overflow),
        .word_count(word_count), .nonzero_cnt(nonzero_cnt), .min_val(min_val),
        .max_val(max_val), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .ch_sel(ch_sel), .ch_count(ch_count)
    );

    // ---------------- larger instance: TOTAL=64, AW=6, CW=2 ----------------
    logic        b_start, b_in_valid, b_rd_en;
    logic [15:0] b_in_data;
    logic [1:0]  b_in_channel, b_ch_sel;
    logic [5:0]  b_rd_addr;
    logic        b_in_ready, b_done, b_overflow, b_rd_valid;
    logic [6:0]  b_word_count, b_nonzero_cnt, b_ch_count;
    logic [15:0] b_min_val, b_max_val, b_rd_data;

    feature_map_collector #(.N(16), .FEATURE_SIZE(4), .OUT_CHANNELS(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_channel(b_in_channel), .in_ready(b_in_ready), .done(b_done), .overflow(b_overflow),
        .word_count(b_word_count), .nonzero_cnt(b_nonzero_cnt), .min_val(b_min_val),
        .max_val(b_max_val), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .ch_sel(b_ch_sel), .ch_count(b_ch_count)
    );

    typedef struct {
        logic [31:0] wc, nz, mn, mx;
    } stat_t;

    logic [15:0] exp_rd_q [$];
    stat_t       exp_stat_q [$];
    logic        done_prev = 1'b0;
    int          b_done_rises = 0;
    logic        b_done_prev = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: read responses and end-of-capture statistics are checked when the DUT presents them
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_rd_q.size() == 0) check("unexpected_rd_valid", 32'd1, 32'd0);
            else check("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
        end
        if (done && !done_prev) begin
            if (exp_stat_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                stat_t s;
                s = exp_stat_q.pop_front();
                check("done_word_count", 32'(word_count), s.wc);
                check("done_nonzero_cnt", 32'(nonzero_cnt), s.nz);
                check("done_min_val", 32'(min_val), s.mn);
                check("done_max_val", 32'(max_val), s.mx);
            end
        end
        done_prev <= done;
        if (b_done && !b_done_prev) b_done_rises++;
        b_done_prev <= b_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic [0:0] ch);
        in_valid = 1'b1; in_data = d; in_channel = ch;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_chan(input string nm, input logic [0:0] ch, input logic [31:0] exp);
        ch_sel = ch;
        #1;
        check(nm, 32'(ch_count), exp);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
        check({tag, "_nonzero_cnt"}, 32'(nonzero_cnt), 32'd0);
        check({tag, "_min_val"}, 32'(min_val), 32'hFFFF);
        check({tag, "_max_val"}, 32'(max_val), 32'h0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        check_chan({tag, "_ch0"}, 1'b0, 32'd0);
        check_chan({tag, "_ch1"}, 1'b1, 32'd0);
    endtask

    logic [15:0] t1_data [8] = '{16'h0, 16'h5, 16'h0, 16'h3, 16'h9, 16'h0, 16'h1, 16'h2};
    logic [15:0] t5_data [8] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};

    initial begin
        logic [15:0] m_min, m_max, w;
        int          m_nz;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_channel = '0;
        rd_en = 1'b0; rd_addr = '0; ch_sel = '0;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_channel = '0;
        b_rd_en = 1'b0; b_rd_addr = '0; b_ch_sel = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_state("reset");

        // Beat before any start is dropped silently
        beat(16'h1234, 1'b0);
        check("prestart_overflow", 32'(overflow), 32'd0);
        check("prestart_word_count", 32'(word_count), 32'd0);

        // Test 1: 8 beats, alternating channel
        exp_stat_q.push_back('{32'd8, 32'd5, 32'h1, 32'h9});
        pulse_start();
        check("t1_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t1_done_before_last", 32'(done), 32'd0);
            beat(t1_data[i], 1'(i % 2));
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_in_ready_off", 32'(in_ready), 32'd0);
        check_chan("t1_ch0", 1'b0, 32'd4);
        check_chan("t1_ch1", 1'b1, 32'd4);

        // Test 2: back-to-back reads
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; rd_addr = 3'(i);
            exp_rd_q.push_back(t1_data[i]);
            tick();
        end
        rd_en = 1'b0;
        repeat (2) tick();
        check("t2_reads_drained", 32'(exp_rd_q.size()), 32'd0);

        // Test 3: beat in DONE raises overflow; start clears it
        beat(16'h00FF, 1'b0);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_word_count", 32'(word_count), 32'd8);
        check("t3_max_val", 32'(max_val), 32'h9);
        tick();
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        pulse_start();
        check("t3_overflow_clr", 32'(overflow), 32'd0);
        check("t3_word_count_clr", 32'(word_count), 32'd0);
        check("t3_done_clr", 32'(done), 32'd0);
        check("t3_min_clr", 32'(min_val), 32'hFFFF);
        // a read outside DONE must not produce rd_valid
        rd_en = 1'b1; rd_addr = 3'd1;
        tick();
        rd_en = 1'b0;

        // Test 4: all zeros
        exp_stat_q.push_back('{32'd8, 32'd0, 32'hFFFF, 32'h0});
        for (int i = 0; i < 8; i++) beat(16'h0, 1'(i % 2));
        check("t4_done", 32'(done), 32'd1);
        check("t4_min_val", 32'(min_val), 32'hFFFF);
        check_chan("t4_ch1", 1'b1, 32'd4);

        // Test 5: beat coincident with start is dropped; gapped stream
        exp_stat_q.push_back('{32'd8, 32'd8, 32'd10, 32'd80});
        in_valid = 1'b1; in_data = 16'd7; in_channel = 1'b0;
        pulse_start();
        in_valid = 1'b0;
        check("t5_start_beat_dropped", 32'(word_count), 32'd0);
        for (int k = 0; k < 8; k++) begin
            beat(t5_data[k], (k < 6) ? 1'b1 : 1'b0);
            if (k < 7) begin
                tick();
                check("t5_not_done_yet", 32'(done), 32'd0);
            end
        end
        check("t5_done", 32'(done), 32'd1);
        check_chan("t5_ch0", 1'b0, 32'd2);
        check_chan("t5_ch1", 1'b1, 32'd6);
        rd_en = 1'b1; rd_addr = 3'd0;
        exp_rd_q.push_back(16'd10);
        tick();
        rd_en = 1'b0; rd_addr = 3'd7;
        exp_rd_q.push_back(16'd80);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        repeat (2) tick();

        // Reset in the middle of a capture
        pulse_start();
        for (int k = 0; k < 3; k++) beat(16'h0100 + 16'(k), 1'(k % 2));
        check("t5_mid_word_count", 32'(word_count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midrst");

        // Test 6: longer capture, round-robin channels, against a running model
        m_min = 16'hFFFF; m_max = 16'h0; m_nz = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            w = (i % 5 == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
            if (w != 0) begin
                m_nz++;
                if (w < m_min) m_min = w;
            end
            if (w > m_max) m_max = w;
            b_in_valid = 1'b1; b_in_data = w; b_in_channel = 2'(i % 4);
            tick();
        end
        b_in_valid = 1'b0;
        check("t6_done", 32'(b_done), 32'd1);
        check("t6_word_count", 32'(b_word_count), 32'd64);
        check("t6_nonzero_cnt", 32'(b_nonzero_cnt), 32'(m_nz));
        check("t6_min_val", 32'(b_min_val), 32'(m_min));
        check("t6_max_val", 32'(b_max_val), 32'(m_max));
        for (int c = 0; c < 4; c++) begin
            b_ch_sel = 2'(c);
            #1;
            check("t6_ch_count", 32'(b_ch_count), 32'd16);
        end
        repeat (4) tick();
        check("t6_done_once", 32'(b_done_rises), 32'd1);
        check("t6_overflow", 32'(b_overflow), 32'd0);

        check("final_rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
        check("final_stat_queue_empty", 32'(exp_stat_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
